// File: rtl/mm_bram_responder.sv
`default_nettype none
// ============================================================================
// Module : mm_bram_responder
// BRAM-port slave for the Montgomery multiplier with a host req/ack port,
// sticky error flag and saturating access counters.
// Rev    : 1.0
// ============================================================================

module mm_bram_responder #(
    parameter int DEPTH_WORDS  = 64,
    parameter int READ_LATENCY = 1,
    parameter int HOST_AW      = 6
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               BRAM_en_i,
    input  logic [3:0]         BRAM_we_i,
    input  logic [31:0]        BRAM_addr_i,
    input  logic [31:0]        BRAM_din_i,
    output logic [31:0]        BRAM_dout_o,
    input  logic               BRAM_rst_i,
    input  logic               host_req_i,
    input  logic               host_we_i,
    input  logic [HOST_AW-1:0] host_addr_i,
    input  logic [31:0]        host_wdata_i,
    output logic               host_ack_o,
    output logic [31:0]        host_rdata_o,
    output logic               err_o,
    input  logic               err_clear_i,
    output logic [15:0]        rd_count_o,
    output logic [15:0]        wr_count_o
);

    localparam int          AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] c_depth = 32'(DEPTH_WORDS);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } host_state_t;

    logic [31:0] mem [DEPTH_WORDS];

    host_state_t state_q, state_d;
    logic        rd0_vld_q, rd0_vld_d;
    logic [31:0] rd0_data_q, rd0_data_d;
    logic [31:0] dout_q, dout_d;
    logic [31:0] host_rdata_q, host_rdata_d;
    logic        err_q, err_d;
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    logic          w_bram_rd;
    logic          w_bram_wr;
    logic          w_bram_oor;
    logic          w_bram_misal;
    logic [AW-1:0] w_bram_idx;
    logic [31:0]   w_bram_rdata;
    logic          w_host_go;
    logic          w_host_oor;
    logic [AW-1:0] w_host_idx;
    logic          w_new_err;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_idx;
    logic [3:0]    w_wr_be;
    logic [31:0]   w_wr_data;
    logic          w_land_vld;
    logic [31:0]   w_land_data;

    always_comb begin
        w_bram_rd    = BRAM_en_i && (BRAM_we_i == 4'h0);
        w_bram_wr    = BRAM_en_i && (BRAM_we_i != 4'h0);
        w_bram_oor   = ({2'b00, BRAM_addr_i[31:2]} >= c_depth);
        w_bram_misal = (BRAM_addr_i[1:0] != 2'b00);
        w_bram_idx   = BRAM_addr_i[AW+1:2];
        w_bram_rdata = w_bram_oor ? 32'h0 : mem[w_bram_idx];
        w_host_oor   = (32'(host_addr_i) >= c_depth);
        w_host_idx   = host_addr_i[AW-1:0];
    end

    // Host FSM: an access only goes through on a cycle the BRAM port is idle.
    always_comb begin
        state_d      = state_q;
        w_host_go    = 1'b0;
        host_rdata_d = host_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (host_req_i && !BRAM_en_i) begin
                    w_host_go = 1'b1;
                    state_d   = ST_ACK;
                    if (!host_we_i) begin
                        host_rdata_d = w_host_oor ? 32'h0 : mem[w_host_idx];
                    end
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Single write port shared by BRAM and host; they are mutually exclusive.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = w_bram_idx;
        w_wr_be   = BRAM_we_i;
        w_wr_data = BRAM_din_i;
        if (w_bram_wr && !w_bram_oor) begin
            w_wr_en = 1'b1;
        end else if (w_host_go && host_we_i && !w_host_oor) begin
            w_wr_en   = 1'b1;
            w_wr_idx  = w_host_idx;
            w_wr_be   = 4'hF;
            w_wr_data = host_wdata_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (w_wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (w_wr_be[k]) begin
                    mem[w_wr_idx][8*k +: 8] <= w_wr_data[8*k +: 8];
                end
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic        rd1_vld_q, rd1_vld_d;
            logic [31:0] rd1_data_q, rd1_data_d;

            always_comb begin
                rd1_vld_d  = rd0_vld_q;
                rd1_data_d = rd0_data_q;
            end

            always_ff @(posedge clock_i or negedge reset_i) begin
                if (!reset_i) begin
                    rd1_vld_q  <= 1'b0;
                    rd1_data_q <= 32'h0;
                end else begin
                    rd1_vld_q  <= rd1_vld_d;
                    rd1_data_q <= rd1_data_d;
                end
            end

            assign w_land_vld  = rd1_vld_q;
            assign w_land_data = rd1_data_q;
        end else begin : g_lat1
            assign w_land_vld  = rd0_vld_q;
            assign w_land_data = rd0_data_q;
        end
    endgenerate

    always_comb begin
        rd0_vld_d  = w_bram_rd;
        rd0_data_d = w_bram_rdata;
        // BRAM_rst_i beats a result landing on the same edge.
        if (BRAM_rst_i) begin
            dout_d = 32'h0;
        end else if (w_land_vld) begin
            dout_d = w_land_data;
        end else begin
            dout_d = dout_q;
        end

        w_new_err = (BRAM_en_i && (w_bram_oor || w_bram_misal)) ||
                    (w_host_go && w_host_oor);
        err_d = err_q;
        if (err_clear_i) err_d = 1'b0;
        if (w_new_err)   err_d = 1'b1;

        rd_count_d = rd_count_q;
        if (w_bram_rd && (rd_count_q != 16'hFFFF)) rd_count_d = rd_count_q + 16'd1;
        wr_count_d = wr_count_q;
        if (w_bram_wr && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= ST_IDLE;
            rd0_vld_q    <= 1'b0;
            rd0_data_q   <= 32'h0;
            dout_q       <= 32'h0;
            host_rdata_q <= 32'h0;
            err_q        <= 1'b0;
            rd_count_q   <= 16'h0;
            wr_count_q   <= 16'h0;
        end else begin
            state_q      <= state_d;
            rd0_vld_q    <= rd0_vld_d;
            rd0_data_q   <= rd0_data_d;
            dout_q       <= dout_d;
            host_rdata_q <= host_rdata_d;
            err_q        <= err_d;
            rd_count_q   <= rd_count_d;
            wr_count_q   <= wr_count_d;
        end
    end

    assign BRAM_dout_o  = dout_q;
    assign host_ack_o   = (state_q == ST_ACK);
    assign host_rdata_o = host_rdata_q;
    assign err_o        = err_q;
    assign rd_count_o   = rd_count_q;
    assign wr_count_o   = wr_count_q;

endmodule

`default_nettype wire

// File: tb/tb_mm_bram_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_mm_bram_responder
// Directed bench driving READ_LATENCY=1 and =2 instances with identical stimulus.
// Rev    : 1.0
// ============================================================================

module tb_mm_bram_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  we = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] din = 32'h0;
    logic        brst = 1'b0;
    logic        req = 1'b0;
    logic        hwe = 1'b0;
    logic [5:0]  haddr = 6'h0;
    logic [31:0] hwdata = 32'h0;
    logic        clr = 1'b0;

    logic [31:0] dout1, dout2, rdata1, rdata2;
    logic        ack1, ack2, err1, err2;
    logic [15:0] rdc1, rdc2, wrc1, wrc2;

    int checks = 0;
    int failures = 0;
    int rd_m = 0;
    int wr_m = 0;

    always #5 clk = ~clk;

    mm_bram_responder #(.DEPTH_WORDS(64), .READ_LATENCY(1), .HOST_AW(6)) u_dut1 (
        .clock_i(clk), .reset_i(rst_n), .BRAM_en_i(en), .BRAM_we_i(we),
        .BRAM_addr_i(addr), .BRAM_din_i(din), .BRAM_dout_o(dout1), .BRAM_rst_i(brst),
        .host_req_i(req), .host_we_i(hwe), .host_addr_i(haddr), .host_wdata_i(hwdata),
        .host_ack_o(ack1), .host_rdata_o(rdata1), .err_o(err1), .err_clear_i(clr),
        .rd_count_o(rdc1), .wr_count_o(wrc1)
    );

    mm_bram_responder #(.DEPTH_WORDS(64), .READ_LATENCY(2), .HOST_AW(6)) u_dut2 (
        .clock_i(clk), .reset_i(rst_n), .BRAM_en_i(en), .BRAM_we_i(we),
        .BRAM_addr_i(addr), .BRAM_din_i(din), .BRAM_dout_o(dout2), .BRAM_rst_i(brst),
        .host_req_i(req), .host_we_i(hwe), .host_addr_i(haddr), .host_wdata_i(hwdata),
        .host_ack_o(ack2), .host_rdata_o(rdata2), .err_o(err2), .err_clear_i(clr),
        .rd_count_o(rdc2), .wr_count_o(wrc2)
    );

    typedef struct {
        logic        en;
        logic [3:0]  we;
        logic [31:0] addr;
        logic [31:0] din;
        logic        brst;
        logic        clr;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eerr;
    } vec_t;

    vec_t tv [27];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] sat16(input int v);
        return (v > 65535) ? 16'hFFFF : 16'(v);
    endfunction

    task automatic host_write(input logic [5:0] a, input logic [31:0] d);
        req = 1'b1; hwe = 1'b1; haddr = a; hwdata = d;
        step();
        chk("hw_ack", {31'b0, ack1}, 32'h1);
        req = 1'b0; hwe = 1'b0;
        step();
        chk("hw_ack_drop", {31'b0, ack1}, 32'h0);
    endtask

    initial begin
        //            en    we     addr          din           brst  clr   e1            e2            err
        tv[0]  = '{1'b1, 4'h0, 32'h0000000C, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
        tv[1]  = '{1'b1, 4'h5, 32'h00000010, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0001ABCD, 32'h0,        1'b0};
        tv[2]  = '{1'b1, 4'h0, 32'h00000010, 32'h0,        1'b0, 1'b0, 32'h0001ABCD, 32'h0001ABCD, 1'b0};
        tv[3]  = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h00FF00FF, 32'h0001ABCD, 1'b0};
        tv[4]  = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h00FF00FF, 32'h00FF00FF, 1'b0};
        tv[5]  = '{1'b1, 4'hF, 32'h00000014, 32'hDEADBEEF, 1'b0, 1'b0, 32'h00FF00FF, 32'h00FF00FF, 1'b0};
        tv[6]  = '{1'b1, 4'h0, 32'h00000014, 32'h0,        1'b0, 1'b0, 32'h00FF00FF, 32'h00FF00FF, 1'b0};
        tv[7]  = '{1'b1, 4'h8, 32'h00000014, 32'h11223344, 1'b0, 1'b0, 32'hDEADBEEF, 32'h00FF00FF, 1'b0};
        tv[8]  = '{1'b1, 4'h0, 32'h00000014, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        tv[9]  = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h11ADBEEF, 32'hDEADBEEF, 1'b0};
        tv[10] = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0,        32'h0,        1'b0};
        tv[11] = '{1'b1, 4'h0, 32'h0000000C, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0};
        tv[12] = '{1'b1, 4'h0, 32'h00000102, 32'h0,        1'b0, 1'b0, 32'h0001ABCD, 32'h0,        1'b1};
        tv[13] = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0,        32'h0001ABCD, 1'b1};
        tv[14] = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1, 32'h0,        32'h0,        1'b0};
        tv[15] = '{1'b1, 4'h0, 32'h00000011, 32'h0,        1'b0, 1'b1, 32'h0,        32'h0,        1'b1};
        tv[16] = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1, 32'h00FF00FF, 32'h0,        1'b0};
        tv[17] = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h00FF00FF, 32'h00FF00FF, 1'b0};
        tv[18] = '{1'b1, 4'hF, 32'h00000016, 32'hCAFEF00D, 1'b0, 1'b0, 32'h00FF00FF, 32'h00FF00FF, 1'b1};
        tv[19] = '{1'b1, 4'h0, 32'h00000014, 32'h0,        1'b0, 1'b0, 32'h00FF00FF, 32'h00FF00FF, 1'b1};
        tv[20] = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'hCAFEF00D, 32'h00FF00FF, 1'b1};
        tv[21] = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1};
        tv[22] = '{1'b1, 4'hF, 32'h00000000, 32'h55AA55AA, 1'b0, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1};
        tv[23] = '{1'b1, 4'hF, 32'h00000100, 32'h12345678, 1'b0, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1};
        tv[24] = '{1'b1, 4'h0, 32'h00000000, 32'h0,        1'b0, 1'b0, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1};
        tv[25] = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h55AA55AA, 32'hCAFEF00D, 1'b1};
        tv[26] = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h55AA55AA, 32'h55AA55AA, 1'b1};

        // Reset state
        #12;
        chk("rst_dout1", dout1, 32'h0);
        chk("rst_ack1", {31'b0, ack1}, 32'h0);
        chk("rst_err1", {31'b0, err1}, 32'h0);
        chk("rst_rdc1", {16'h0, rdc1}, 32'h0);
        chk("rst_wrc1", {16'h0, wrc1}, 32'h0);
        step();
        rst_n = 1'b1;

        host_write(6'd3, 32'h0001ABCD);
        host_write(6'd4, 32'h00000000);

        foreach (tv[i]) begin
            en = tv[i].en; we = tv[i].we; addr = tv[i].addr; din = tv[i].din;
            brst = tv[i].brst; clr = tv[i].clr;
            if (tv[i].en) begin
                if (tv[i].we == 4'h0) rd_m++;
                else wr_m++;
            end
            step();
            chk($sformatf("row%0d_dout1", i), dout1, tv[i].e1);
            chk($sformatf("row%0d_dout2", i), dout2, tv[i].e2);
            chk($sformatf("row%0d_err", i), {31'b0, err1}, {31'b0, tv[i].eerr});
            chk($sformatf("row%0d_rdc", i), {16'h0, rdc1}, {16'h0, sat16(rd_m)});
            chk($sformatf("row%0d_wrc", i), {16'h0, wrc2}, {16'h0, sat16(wr_m)});
        end
        en = 1'b0; we = 4'h0; brst = 1'b0; clr = 1'b0;

        // Host read of a byte-masked BRAM write, single-cycle ack
        req = 1'b1; hwe = 1'b0; haddr = 6'd4;
        step();
        chk("hrd_ack", {31'b0, ack1}, 32'h1);
        chk("hrd_data", rdata1, 32'h00FF00FF);
        chk("hrd_data2", rdata2, 32'h00FF00FF);
        req = 1'b0;
        step();
        chk("hrd_ack_once", {31'b0, ack1}, 32'h0);

        // Host stall while the BRAM port is busy
        req = 1'b1; hwe = 1'b0; haddr = 6'd3;
        en = 1'b1; we = 4'h0; addr = 32'h14;
        for (int c = 0; c < 5; c++) begin
            rd_m++;
            step();
            chk($sformatf("stall%0d_ack", c), {31'b0, ack1}, 32'h0);
        end
        en = 1'b0;
        step();
        chk("stall_ack", {31'b0, ack1}, 32'h1);
        chk("stall_rdata", rdata1, 32'h0001ABCD);
        chk("stall_dout1", dout1, 32'hCAFEF00D);
        req = 1'b0;
        step();
        chk("stall_ack_drop", {31'b0, ack2}, 32'h0);
        chk("stall_dout2", dout2, 32'hCAFEF00D);

        // Read counter saturation
        en = 1'b1; we = 4'h0; addr = 32'h0;
        for (int c = 0; c < 70000; c++) begin
            rd_m++;
            step();
        end
        en = 1'b0;
        chk("sat_rdc1", {16'h0, rdc1}, 32'h0000FFFF);
        chk("sat_rdc2", {16'h0, rdc2}, 32'h0000FFFF);
        chk("sat_wrc", {16'h0, wrc1}, {16'h0, sat16(wr_m)});
        step();
        chk("sat_dout1", dout1, 32'h55AA55AA);

        // Reset with a read in flight
        en = 1'b1; addr = 32'h10;
        step();
        en = 1'b0; rst_n = 1'b0;
        #1;
        chk("mrst_dout1", dout1, 32'h0);
        chk("mrst_dout2", dout2, 32'h0);
        chk("mrst_rdc", {16'h0, rdc1}, 32'h0);
        chk("mrst_wrc", {16'h0, wrc1}, 32'h0);
        step();
        chk("mrst_dout2_hold", dout2, 32'h0);
        rst_n = 1'b1;
        step();
        step();
        chk("mrst_dout1_after", dout1, 32'h0);
        chk("mrst_dout2_after", dout2, 32'h0);

        // Reset in the ACK cycle
        req = 1'b1; hwe = 1'b0; haddr = 6'd3;
        step();
        chk("arst_ack_pre", {31'b0, ack1}, 32'h1);
        req = 1'b0; rst_n = 1'b0;
        #1;
        chk("arst_ack", {31'b0, ack1}, 32'h0);
        chk("arst_rdata", rdata1, 32'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_ack_after", {31'b0, ack1}, 32'h0);

        // Array contents survive reset
        en = 1'b1; we = 4'h0; addr = 32'hC;
        step();
        en = 1'b0;
        step();
        chk("keep_dout1", dout1, 32'h0001ABCD);
        step();
        chk("keep_dout2", dout2, 32'h0001ABCD);
        chk("keep_rdc", {16'h0, rdc2}, 32'h1);
        req = 1'b1; hwe = 1'b0; haddr = 6'd5;
        step();
        chk("keep_host", rdata1, 32'hCAFEF00D);
        req = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mm_bram_responder.md
# mm_bram_responder

Slave-side responder for the 32-bit Xilinx-style BRAM master port driven by the Montgomery multiplier wrapper. It stores operand and result words and answers the multiplier's byte-addressed, word-aligned accesses with a fixed read latency. A second host port with a req/ack handshake lets the processor load operands and read back results. The block also keeps sticky error and access statistics for bring-up and verification.

## Interface
Parameters:
- DEPTH_WORDS, 64, number of 32-bit words stored; word index = BRAM_addr_i[31:2].
- READ_LATENCY, 1, BRAM read latency in cycles; legal values are 1 or 2.
- HOST_AW, 6, width of host word index; must satisfy 2^HOST_AW >= DEPTH_WORDS.

Ports:
- clock_i  in  1  single clock; the BRAM master runs on this same clock.
- reset_i  in  1  asynchronous, active-low reset.
- BRAM_en_i  in  1  access enable from the multiplier.
- BRAM_we_i  in  4  byte write enables; any bit set makes the access a write.
- BRAM_addr_i  in  32  byte address.
- BRAM_din_i  in  32  write data.
- BRAM_dout_o  out  32  read data.
- BRAM_rst_i  in  1  synchronous, active-high clear of the dout register(s) only.
- host_req_i  in  1  host access request; held high until host_ack_o.
- host_we_i  in  1  host write (1) or read (0).
- host_addr_i  in  HOST_AW  host word index.
- host_wdata_i  in  32  host write data (full word).
- host_ack_o  out  1  one-cycle completion pulse.
- host_rdata_o  out  32  host read data, valid while host_ack_o=1.
- err_o  out  1  sticky access error.
- err_clear_i  in  1  clears err_o.
- rd_count_o  out  16  BRAM-port read count, saturating.
- wr_count_o  out  16  BRAM-port write count, saturating.

## Operation
- The memory array is not cleared by reset. All registers and outputs reset to 0.
- **BRAM port has absolute priority.** It is serviced every cycle BRAM_en_i=1.
  - Write: update each byte k where BRAM_we_i[k]=1; other bytes are unchanged.
  - Read: the pipeline returns the full stored word.
  - Read-during-write to the same port is read-first: dout returns the old word.
- **Out-of-range access** (word index >= DEPTH_WORDS):
  - Write is dropped.
  - Read returns 32'h0.
  - err_o is set.
- **Misaligned access** (BRAM_addr_i[1:0] != 0):
  - The access is performed at word index addr[31:2].
  - err_o is set.
- err_o is sticky until err_clear_i=1. If err_clear_i and a new error occur in the same cycle, set wins.
- Counters increment once per enabled BRAM read or write cycle and saturate at 16'hFFFF. Out-of-range accesses are still counted.
- **Host FSM, two states:**
  - IDLE: if host_req_i=1 and BRAM_en_i=0, perform the access and go to ACK. If BRAM_en_i=1, stay in IDLE (stall).
  - ACK: host_ack_o=1 and host_rdata_o is valid; return to IDLE unconditionally. host_req_i is not sampled in ACK.
- Host writes are full-word. Host indices >= DEPTH_WORDS are dropped (reads return 0), and the error is also flagged on err_o.
- Host and BRAM never access the array in the same cycle, so there is no port collision.

## Timing
- BRAM read: address is sampled at edge N with BRAM_en_i=1. BRAM_dout_o is valid after edge N+READ_LATENCY and held until the next read result.
- BRAM write: the array is updated at edge N. A read at N+1 of the same address returns the new data.
- BRAM_rst_i at edge N forces BRAM_dout_o=0 after edge N and takes priority over a read result landing at the same edge. It does not affect the array or counters.
- Host: request accepted at edge N (IDLE, no BRAM_en_i). host_ack_o and host_rdata_o are high for exactly the cycle after edge N. Maximum host throughput is one access per 2 cycles.
- A host stall lasts for as long as BRAM_en_i stays high; there is no timeout.
- Reset asserted mid-operation:
  - Pending ack is lost and the FSM returns to IDLE.
  - Any in-flight read pipeline stage is cleared to 0.
  - The host must re-issue the request.
- After reset deassertion, the first access is accepted at the first edge with reset_i=1.

## Test plan
- Host writes 32'h0001ABCD to index 3, then the BRAM port reads addr 32'hC → BRAM_dout_o=32'h0001ABCD exactly READ_LATENCY cycles after the read (check both 1 and 2).
- BRAM writes 32'hFFFFFFFF with we=4'b0101 over stored 32'h0 at addr 32'h10, then the host reads index 4 → host_rdata_o=32'h00FF00FF with a one-cycle host_ack_o.
- Host holds req while BRAM_en_i=1 for 5 cycles → no ack during those cycles. Ack arrives 1 cycle after the BRAM access stops, and the BRAM data is undisturbed.
- BRAM reads addr 32'h0000_0102 → err_o=1 and data from word 64 reads as 0 (DEPTH_WORDS=64). err_clear_i then clears err_o, and a same-cycle new error keeps it at 1.
- Issue 70000 BRAM reads → rd_count_o saturates at 16'hFFFF. wr_count_o is unaffected.
- Drive reset_i low in the ACK cycle and during a READ_LATENCY=2 read → host_ack_o, BRAM_dout_o and the counters are 0 while reset is asserted. Array contents written earlier read back unchanged after release.
